dassign1_loader: RTL and testbench
==================================

Name: dassign1_loader

Overview:
- Serial-to-parallel input stage that feeds the 7-input combinational logic function block (inputs a..g).
- Collects a serial bit stream into NBITS-bit frames, first bit received = a.
- Holds each completed frame stable on a parallel bus under a valid/ready handshake, so the downstream logic sees glitch-free, frame-aligned operands.
- Supports backpressure, frame resynchronisation and delivered-frame counting.

Parameters:
NBITS, 7, frame width in bits (one bit per downstream logic input; vec[NBITS-1] = a ... vec[0] = g).
CNTW, 8, width of delivered-frame counter.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
sin  input  1  serial data bit
sin_valid  input  1  sin carries a bit this cycle
sin_ready  output  1  block accepts a bit this cycle
sync  input  1  synchronous frame realign: discard partial/pending frame
vec  output  NBITS  parallel frame to downstream logic (MSB = first bit received)
vec_valid  output  1  vec holds an undelivered frame
vec_ready  input  1  downstream consumes vec this cycle
frame_cnt  output  CNTW  count of delivered frames (vec handshakes)

Behaviour:
- Reset (rst_n low, asynchronous): shift register, bit count, vec, vec_valid, frame_cnt all 0. sin_ready = 1 once sync is low.
- sin_ready is combinational: sin_ready = !sync && (bitcnt != NBITS).
- Bit accept: sin_valid && sin_ready at a rising edge. shreg <= {shreg[NBITS-2:0], sin}, bitcnt <= bitcnt + 1.
- The hold register is free when vec_valid == 0, or when vec_valid && vec_ready in the same cycle.
- States, derived from bitcnt:
  - COLLECT: bitcnt 0..NBITS-1.
  - PEND: bitcnt == NBITS. A complete frame waits in shreg because the hold register was occupied.
- Frame completion (the accepted bit is bit NBITS of the frame):
  - If the hold register is free: vec <= {shreg[NBITS-2:0], sin}, vec_valid <= 1, bitcnt <= 0. Latency: vec_valid high the cycle after the last bit is accepted.
  - Otherwise: shreg takes the bit, bitcnt <= NBITS (enter PEND), sin_ready drops.
- PEND, on vec_valid && vec_ready: vec <= shreg, vec_valid stays 1, bitcnt <= 0. sin_ready returns the next cycle.
- Handshake with no replacement frame: vec_valid <= 0. vec keeps its last value.
- vec and vec_valid are stable while vec_valid && !vec_ready.
- frame_cnt increments by 1 on every vec_valid && vec_ready. It wraps 2^CNTW-1 -> 0.
- sync (priority over bit accept):
  - shreg <= 0, bitcnt <= 0. The sin bit in that cycle is not accepted.
  - A pending frame in PEND is discarded.
  - The hold register, vec_valid and frame_cnt are unaffected. A vec handshake in the same cycle still completes normally.
- Simultaneous final-bit accept and vec handshake: the new frame loads, vec_valid stays 1, frame_cnt increments.
- sin_valid while sin_ready = 0: the bit is ignored; no state change.
- Reset mid-frame or mid-PEND: all state cleared immediately, without waiting for clk.

Test Plan:
- Reset, vec_ready = 1, send bits 1,1,1,1,0,0,0 on consecutive cycles -> vec = 7'h78, vec_valid high exactly 1 cycle starting the cycle after bit 7, then frame_cnt = 1.
- vec_ready = 0, send frame 7'h78 then frame 7'h05 -> after 14th bit sin_ready = 0, vec = 7'h78 stable. Pulse vec_ready 1 cycle -> next cycle vec = 7'h05, vec_valid = 1, sin_ready = 1, frame_cnt = 1.
- Send bits 1,0,1, assert sync 1 cycle (with sin_valid = 1, sin = 1), then send 7'h2A -> vec = 7'h2A, frame_cnt = 1 after handshake.
- Hold register occupied with 7'h78, vec_ready raised in the same cycle bit 7 of 7'h13 is accepted -> next cycle vec = 7'h13, vec_valid = 1 continuously, frame_cnt = 1.
- vec_valid = 1, frame_cnt = 3, bitcnt = 4: drop rst_n between clock edges -> vec = 0, vec_valid = 0, frame_cnt = 0 immediately. After release, a full frame 7'h7F delivers normally.
- Deliver 256 frames with vec_ready = 1 -> frame_cnt reads 255 after the 255th, 0 after the 256th.

Source files
------------

// File: rtl/dassign1_loader.sv
// dassign1_loader: serial-to-parallel frame loader with a valid/ready hold register.
// It assembles NBITS-bit frames, first bit received = MSB, and it counts delivered frames.
module dassign1_loader #(
  parameter int NBITS = 7,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             sync,
  output logic [NBITS-1:0] vec,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [CNTW-1:0]  frame_cnt
);
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [BW-1:0] FULL = BW'(NBITS);
  localparam logic [BW-1:0] LAST = BW'(NBITS - 1);
  logic [NBITS-1:0] r_shreg, r_vec;
  logic [BW-1:0]    r_bitcnt;
  logic             r_vec_valid;
  logic [CNTW-1:0]  r_frame_cnt;
  logic             w_accept, w_pend, w_hs, w_free, w_load;
  logic [NBITS-1:0] w_frame;
  assign sin_ready = !sync && (r_bitcnt != FULL);
  assign w_accept  = sin_valid && sin_ready;
  assign w_pend    = r_bitcnt == FULL;
  assign w_hs      = r_vec_valid && vec_ready;
  assign w_free    = !r_vec_valid || vec_ready;
  // A completing bit goes straight to the hold register when it is free; otherwise the frame waits in PEND.
  assign w_load    = w_accept && (r_bitcnt == LAST) && w_free;
  assign w_frame   = {r_shreg[NBITS-2:0], sin};
  assign vec       = r_vec;
  assign vec_valid = r_vec_valid;
  assign frame_cnt = r_frame_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_vec       <= '0;
      r_vec_valid <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + CNTW'(w_hs);
      if (sync) begin
        r_shreg  <= '0;
        r_bitcnt <= '0;
      end else if (w_accept) begin
        r_shreg  <= w_frame;
        r_bitcnt <= w_load ? '0 : r_bitcnt + 1'b1;
      end else if (w_pend && w_hs) begin
        r_bitcnt <= '0;
      end
      if (w_load) begin
        r_vec       <= w_frame;
        r_vec_valid <= 1'b1;
      end else if (!sync && w_pend && w_hs) begin
        r_vec       <= r_shreg;
        r_vec_valid <= 1'b1;
      end else if (w_hs) begin
        r_vec_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dassign1_loader.sv
// tb_dassign1_loader: directed-vector bench for dassign1_loader.
module tb_dassign1_loader;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sin = 1'b0, sin_valid = 1'b0, sync = 1'b0, vec_ready = 1'b0;
  logic       sin_ready, vec_valid;
  logic [6:0] vec;
  logic [7:0] frame_cnt;
  int         n_tests = 0, n_fail = 0;

  dassign1_loader #(.NBITS(7), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready),
    .sync(sync), .vec(vec), .vec_valid(vec_valid), .vec_ready(vec_ready), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sin_valid = 1'b0; sync = 1'b0; vec_ready = 1'b0; sin = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    sin_valid = 1'b1;
    tick();
  endtask

  task automatic send_frame(input logic [6:0] f);
    for (int k = 6; k >= 0; k--) send_bit(f[k]);
    sin_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] f13;
    f13 = 7'h13;
    // basic frame, always-ready downstream
    do_reset();
    chk("rst_vec", 32'(vec), 0);
    chk("rst_valid", 32'(vec_valid), 0);
    chk("rst_cnt", 32'(frame_cnt), 0);
    chk("rst_sin_ready", 32'(sin_ready), 1);
    vec_ready = 1'b1;
    send_frame(7'h78);
    chk("t1_vec", 32'(vec), 32'h78);
    chk("t1_valid", 32'(vec_valid), 1);
    chk("t1_cnt_before", 32'(frame_cnt), 0);
    tick();
    chk("t1_valid_drop", 32'(vec_valid), 0);
    chk("t1_cnt", 32'(frame_cnt), 1);
    chk("t1_vec_kept", 32'(vec), 32'h78);

    // backpressure into PEND
    do_reset();
    send_frame(7'h78);
    send_frame(7'h05);
    chk("t2_sin_ready", 32'(sin_ready), 0);
    chk("t2_vec_hold", 32'(vec), 32'h78);
    send_bit(1'b1);
    sin_valid = 1'b0;
    chk("t2_ignored_vec", 32'(vec), 32'h78);
    chk("t2_ignored_ready", 32'(sin_ready), 0);
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    chk("t2_vec_pend", 32'(vec), 32'h05);
    chk("t2_valid_pend", 32'(vec_valid), 1);
    chk("t2_sin_ready_back", 32'(sin_ready), 1);
    chk("t2_cnt", 32'(frame_cnt), 1);
    tick();
    chk("t2_stable", 32'(vec), 32'h05);
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    chk("t2_valid_drop", 32'(vec_valid), 0);
    chk("t2_cnt2", 32'(frame_cnt), 2);

    // sync discards a partial frame and the bit presented with it
    do_reset();
    vec_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    sync = 1'b1;
    send_bit(1'b1);
    sync = 1'b0;
    send_frame(7'h2A);
    chk("t3_vec", 32'(vec), 32'h2A);
    chk("t3_valid", 32'(vec_valid), 1);
    tick();
    chk("t3_cnt", 32'(frame_cnt), 1);

    // final bit and handshake in the same cycle
    do_reset();
    send_frame(7'h78);
    for (int k = 6; k >= 1; k--) send_bit(f13[k]);
    sin = f13[0];
    vec_ready = 1'b1;
    tick();
    sin_valid = 1'b0;
    vec_ready = 1'b0;
    chk("t4_vec", 32'(vec), 32'h13);
    chk("t4_valid", 32'(vec_valid), 1);
    chk("t4_cnt", 32'(frame_cnt), 1);

    // asynchronous reset mid-frame
    do_reset();
    vec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_frame(7'h11);
      tick();
    end
    vec_ready = 1'b0;
    send_frame(7'h66);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    sin_valid = 1'b0;
    chk("t5_pre_cnt", 32'(frame_cnt), 3);
    chk("t5_pre_valid", 32'(vec_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_vec", 32'(vec), 0);
    chk("t5_async_valid", 32'(vec_valid), 0);
    chk("t5_async_cnt", 32'(frame_cnt), 0);
    rst_n = 1'b1;
    vec_ready = 1'b1;
    send_frame(7'h7F);
    chk("t5_vec", 32'(vec), 32'h7F);
    chk("t5_valid", 32'(vec_valid), 1);
    tick();
    chk("t5_cnt", 32'(frame_cnt), 1);

    // counter wrap
    do_reset();
    vec_ready = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      send_frame(7'(i));
      if (i == 255) chk("t6_vec255", 32'(vec), 32'h7F);
      tick();
      if (i == 255) chk("t6_cnt255", 32'(frame_cnt), 255);
      if (i == 256) chk("t6_cnt_wrap", 32'(frame_cnt), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
